fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction queue between the fetch stage and the decode stage. Captures each fetched `{pc, instruction}` pair, buffers up to DEPTH entries in a circular FIFO, and presents them in order to decode through a valid/ready handshake. Absorbs decode stalls without losing fetched words and discards all buffered entries on a control-flow flush (branch/jump redirect).

## Interface
- `DEPTH`, 4: number of entries; power of two, 2..16.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: fetch presents a valid `{in_pc, in_instr}` this cycle.
- `in_pc` in 32: PC of the fetched word.
- `in_instr` in 32: fetched instruction word.
- `in_ready` out 1: queue accepts a word this cycle; fetch holds `next_pc` when low.
- `out_valid` out 1: head entry is valid for decode.
- `out_pc` out 32: PC of the head entry; 0 when `out_valid`=0.
- `out_instr` out 32: instruction of the head entry; 0 when `out_valid`=0.
- `out_ready` in 1: decode consumes the head entry this cycle.
- `flush` in 1: discard all entries and any word offered this cycle.
- `count` out $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.

## Operation
- Storage: DEPTH x 64-bit array, write pointer `wp`, read pointer `rp`, both $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` register tracks occupancy. Array contents are not reset.
- `in_ready` = (`count` != DEPTH), from registered state only; it does not depend on `out_ready`.
- Enqueue = `in_valid` & `in_ready` & ~`flush`: write `{in_pc, in_instr}` at `wp`, `wp` += 1.
- Dequeue = `out_valid` & `out_ready` & ~`flush`: `rp` += 1.
- `count` next = `count` + enqueue - dequeue; simultaneous enqueue and dequeue leaves `count` unchanged.
- Full (`count`=DEPTH): `in_ready`=0; a simultaneous dequeue does not allow an enqueue in the same cycle.
- Empty (`count`=0): `out_valid`=0 unless bypass is active (see Configuration).
- Flush: on the next edge `count`, `wp` and `rp` return to 0. The offered input word and any head consumption in that cycle are dropped. Flush overrides all other events.
- Output masking: `out_pc`/`out_instr` read the entry at `rp` when `out_valid`=1, otherwise 0.
- Reset (at any time, including mid-transfer): `count`=0, `wp`=`rp`=0, `out_valid`=0, `out_pc`=`out_instr`=0, `in_ready`=1. Reset takes effect immediately, without waiting for a clock edge.

## Timing
- Latency without bypass: a word enqueued at edge N appears on the outputs after edge N, i.e. it can be consumed in cycle N+1.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- `flush` asserted in cycle N: `out_valid`=0 and `count`=0 from edge N onward. The first post-flush word can be enqueued in cycle N+1.
- The handshake is level-based. A word is transferred only in a cycle where valid and ready are both high. A producer may change `in_pc`/`in_instr` after a non-accepted cycle.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `count`=0 and `flush`=0, `out_valid`=`in_valid` and the outputs show `in_pc`/`in_instr` combinationally.
  - If `out_ready`=1 in that cycle, the word passes straight to decode: no write, pointers and `count` unchanged.
  - If `out_ready`=0, the word is enqueued normally.
  - Result: zero-cycle latency when the queue is empty.
- Undefined: no combinational path from inputs to outputs; minimum latency is one cycle as above.

## Test plan
- Reset then idle: `rst`=1 mid-stream with `count`=3 -> immediately `count`=0, `out_valid`=0, `out_pc`=0, `in_ready`=1.
- Streaming: enqueue pc 0x0,0x4,0x8,0xC with `out_ready`=1 -> decode receives the same PCs in order, one per cycle, `count` ≤ 1.
- Fill and stall: `out_ready`=0, offer 5 words (DEPTH=4) -> 4 accepted, `in_ready`=0, `count`=4, 5th held. Raise `out_ready` -> pc 0x0 dequeued, then the 5th accepted after that edge.
- Wrap-around: 10 enqueue/dequeue pairs with `count` held at 2 -> order preserved across pointer wrap, `count` stays 2.
- Flush: `count`=3 with `in_valid`=1, `out_ready`=1, `flush`=1 -> next cycle `count`=0, `out_valid`=0, nothing delivered. Next word pc 0x40 is delivered first.
- Bypass (macro defined): empty queue, `in_valid`=1 pc 0x100, `out_ready`=1 -> `out_valid`=1, `out_pc`=0x100 in the same cycle, `count` remains 0. Without the macro -> delivered one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr} pairs with
// valid/ready on both sides and a redirect flush. Define FETCH_QUEUE_BYPASS_EN
// to let a word pass straight through an empty queue in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        empty;
  logic        bypass;
  logic        bypass_take;
  logic        enq;
  logic        deq;
  logic [63:0] head;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue exposes the fetch port directly; a flush still hides it.
  assign bypass = empty & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A word consumed through the bypass never touches the storage array.
  assign bypass_take = bypass & in_valid & out_ready;
  assign enq         = in_valid & in_ready & ~flush & ~bypass_take;
  assign deq         = ~empty & out_ready & ~flush;

  assign head      = mem_q[rp_q];
  assign out_valid = bypass ? in_valid : ~empty;
  assign out_pc    = !out_valid ? 32'h0 : (bypass ? in_pc    : head[63:32]);
  assign out_instr = !out_valid ? 32'h0 : (bypass ? in_instr : head[31:0]);
  assign count     = count_q;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (enq) wp_d = wp_q + 1'b1;
      if (deq) rp_d = rp_q + 1'b1;
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // NOTE: the payload array is deliberately left out of reset; occupancy is
  // tracked by count_q, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wp_q] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic [31:0]            in_pc;
  logic [31:0]            in_instr;
  logic                   in_ready;
  logic                   out_valid;
  logic [31:0]            out_pc;
  logic [31:0]            out_instr;
  logic                   out_ready;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the model, then advance
  // the model across the rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    int          sz;
    logic        e_rdy;
    logic        e_val;
    logic        byp;
    logic [63:0] e_head;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    sz    = model_q.size();
    e_rdy = (sz < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && !fl;
`else
    byp = 1'b0;
`endif
    e_val  = byp ? v : (sz > 0);
    e_head = !e_val ? 64'h0 : (byp ? {pc, ins} : model_q[0]);
    check("count",     64'(count),     64'(sz));
    check("in_ready",  64'(in_ready),  64'(e_rdy));
    if (!fl) check("out_valid", 64'(out_valid), 64'(e_val));
    if (!fl) check("out_pc",    64'(out_pc),    64'(e_head[63:32]));
    if (!fl) check("out_instr", 64'(out_instr), 64'(e_head[31:0]));
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else if (!(byp && v && ordy)) begin
      if (e_val && ordy) void'(model_q.pop_front());
      if (v && e_rdy) model_q.push_back({pc, ins});
    end
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},     64'(count),     64'h0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    check({tag, "_out_pc"},    64'(out_pc),    64'h0);
    check({tag, "_out_instr"}, 64'(out_instr), 64'h0);
    check({tag, "_in_ready"},  64'(in_ready),  64'h1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_init");
    rst = 1'b0;

    // Streaming with decode always ready
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill and stall: five offers, fifth held, then drain one and accept it
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h10, 32'hB000_0004, 1'b1, 1'b0);
    step(1'b1, 32'h10, 32'hB000_0004, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Wrap-around with occupancy held at two
    step(1'b1, 32'h200, 32'hC000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'hC000_0001, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) step(1'b1, 32'h200 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with three entries and a concurrent offer and consume
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h30C, 32'hD000_0003, 1'b1, 1'b1);
    step(1'b1, 32'h40, 32'hE000_0040, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty-queue offer: same-cycle delivery with bypass, next cycle without
    step(1'b1, 32'h100, 32'hF000_0100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with three entries stored
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'(model_q.size()));
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_state("rst_async");
    model_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           $urandom(),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
